// File: rtl/lsu_rmw_master.sv
// lsu_rmw_master: load/store master between the CPU datapath and a
// 1024 x 32-bit word memory. Sub-word stores use read-modify-write, and
// sub-word loads are extracted and extended. Misaligned or illegal accesses
// return an error without touching memory.
// Optional feature macro: LSU_HALFWORD_EN enables lh/lhu/sh. Without it,
// those op codes are illegal and the halfword datapath is not built.
module lsu_rmw_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [9:0]  mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

`ifdef LSU_HALFWORD_EN
  localparam int WDATA_W = 16;
`else
  localparam int WDATA_W = 8;
`endif

  typedef enum logic [2:0] {
    IDLE,
    RD,
    EXT,
    WR,
    RESP
  } state_t;

  state_t             state;
  logic [2:0]         op_q;
  logic [1:0]         offset_q;
  logic [WDATA_W-1:0] wdata_q;

  logic        req_illegal;
  logic        req_misaligned;
  logic        req_err;
  logic        op_is_store;
  logic [7:0]  sel_byte;
  logic [31:0] load_result;
  logic [31:0] merged_word;
`ifdef LSU_HALFWORD_EN
  logic [15:0] sel_half;
`endif

  // The only stores that pass through EXT are sb and sh (op codes 110/111).
  assign op_is_store = op_q[2] & (op_q[1] | op_q[0]);

  // Classify the incoming request as illegal or misaligned before accepting it
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    case (req_op)
      OP_LW, OP_SW: req_misaligned = (req_addr[1:0] != 2'b00);
`ifdef LSU_HALFWORD_EN
      OP_LH, OP_LHU, OP_SH: req_misaligned = req_addr[0];
`else
      OP_LH, OP_LHU, OP_SH: req_illegal = 1'b1;
`endif
      default: req_misaligned = 1'b0;
    endcase
    req_err = req_illegal | req_misaligned;
  end

  // Pick the addressed lanes out of the read word, then build the load result and the merged store word
  always_comb begin
    case (offset_q)
      2'd0:    sel_byte = mem_rdata[7:0];
      2'd1:    sel_byte = mem_rdata[15:8];
      2'd2:    sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
`ifdef LSU_HALFWORD_EN
    sel_half = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
`endif
    load_result = 32'h0;
    merged_word = mem_rdata;
    case (op_q)
      OP_LW:  load_result = mem_rdata;
      OP_LB:  load_result = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU: load_result = {24'h0, sel_byte};
`ifdef LSU_HALFWORD_EN
      OP_LH:  load_result = {{16{sel_half[15]}}, sel_half};
      OP_LHU: load_result = {16'h0, sel_half};
      OP_SH: begin
        if (offset_q[1]) merged_word[31:16] = wdata_q[15:0];
        else             merged_word[15:0]  = wdata_q[15:0];
      end
`endif
      OP_SB: begin
        case (offset_q)
          2'd0:    merged_word[7:0]   = wdata_q[7:0];
          2'd1:    merged_word[15:8]  = wdata_q[7:0];
          2'd2:    merged_word[23:16] = wdata_q[7:0];
          default: merged_word[31:24] = wdata_q[7:0];
        endcase
      end
      default: load_result = 32'h0;
    endcase
  end

  // Request sequencer; every output is registered and set on the transition into the state that owns it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      mem_we     <= 1'b0;
      mem_addr   <= 10'h0;
      mem_wdata  <= 32'h0;
      op_q       <= OP_LW;
      offset_q   <= 2'b00;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            offset_q  <= req_addr[1:0];
            wdata_q   <= req_wdata[WDATA_W-1:0];
            req_ready <= 1'b0;
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
              state      <= RESP;
            end else begin
              mem_addr <= req_addr[11:2];
              if (req_op == OP_SW) begin
                mem_we    <= 1'b1;
                mem_wdata <= req_wdata;
                state     <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          state <= EXT;
        end
        EXT: begin
          if (op_is_store) begin
            mem_we    <= 1'b1;
            mem_wdata <= merged_word;
            state     <= WR;
          end else begin
            resp_rdata <= load_result;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WR: begin
          mem_we     <= 1'b0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_rmw_master.md
# lsu_rmw_master

Load/store master that sits between the single-cycle CPU datapath and the 4 KB word-organised data memory. It accepts one load or store request at a time and turns it into word-wide memory transactions. Sub-word stores are done by read-modify-write, and sub-word loads are extracted and extended. It flags misaligned or illegal accesses instead of touching memory.

## Interface
- No parameters. Memory geometry is fixed at 1024 x 32-bit words, addressed by byte address [11:0].
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present; sampled only when req_ready=1
- req_ready  out  1  block idle and able to accept
- req_op  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 sw, 110 sb, 111 sh
- req_addr  in  12  byte address
- req_wdata  in  32  store data; sub-word stores use low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result (extended); 0 for stores and errors
- resp_err  out  1  valid with resp_valid; misaligned or illegal op
- mem_addr  out  10  word address to data memory
- mem_we  out  1  word write enable
- mem_wdata  out  32  word write data
- mem_rdata  in  32  read data, valid the cycle after mem_addr is presented with mem_we=0

## Operation
- States: IDLE, RD, EXT, WR, RESP.
- IDLE: req_ready=1. On req_valid, the block captures op, addr, and wdata.
  - Illegal or misaligned access goes to RESP with err=1.
  - lw, lb, lbu, lh, lhu, sb, sh go to RD.
  - sw goes to WR.
- RD: drive mem_addr=addr[11:2], mem_we=0; go to EXT.
- EXT: sample mem_rdata.
  - Loads: register the extracted result, then go to RESP.
  - Sub-word stores: merge store data into the sampled word, then go to WR.
- WR: drive mem_addr, mem_we=1, mem_wdata (req_wdata for sw, merged word otherwise); go to RESP.
- RESP: resp_valid=1 for exactly one cycle; go to IDLE.
- Byte lanes are little-endian:
  - Byte offset k selects bits [8k+7:8k].
  - Halfword offset 0 selects [15:0]; offset 2 selects [31:16].
- Extension: lb and lh sign-extend; lbu and lhu zero-extend.
- sb merge replaces only the addressed byte with req_wdata[7:0]. sh merge replaces only the addressed half with req_wdata[15:0]. All other bits are preserved exactly.
- Misaligned means lw/sw with addr[1:0]≠0, or lh/lhu/sh with addr[0]=1. No memory write occurs, and resp_rdata=0.
- There is no response backpressure. The consumer must take resp_valid when it pulses.

## Timing
- Reset values:
  - state=IDLE
  - req_ready=1
  - resp_valid=0, resp_err=0
  - resp_rdata=0
  - mem_we=0, mem_addr=0, mem_wdata=0
- Latency counts from the accept edge (cycle 0) to the resp_valid cycle:

  - Error: 1
  - sw: 2 (mem_we high in cycle 1)
  - Loads: 3
  - sb/sh: 4 (write in cycle 3)
- req_ready is 0 from the cycle after accept through RESP. It returns to 1 in the cycle after RESP, so back-to-back requests are separated by at least one IDLE cycle.
- mem_we is high only in WR and only for one cycle. A single request never causes two writes.
- Reset asserted mid-operation:
  - mem_we and resp_valid drop immediately (asynchronously) and state returns to IDLE.
  - A write already committed in an earlier WR cycle stands.
  - An RMW interrupted before WR leaves memory unchanged.
- req_valid while req_ready=0 is ignored; no queuing.

## Configuration
- LSU_HALFWORD_EN
  - Defined: lh, lhu, and sh are supported as described above.
  - Undefined: op codes 011, 100, and 111 are illegal. They take the error path (1-cycle latency, resp_err=1, no memory access), and the halfword extract/merge logic is not built.

## Test plan
- Reset with all outputs checked, then `sw` addr 0x010 data 0xDEADBEEF → mem_we=1 for one cycle, mem_addr=0x004, mem_wdata=0xDEADBEEF. resp_valid 2 cycles after accept, err=0.
- Memory word 0x004 = 0x80FF7F01:
  - lb at 0x013 → 0xFFFFFF80
  - lbu at 0x013 → 0x00000080
  - lb at 0x010 → 0x00000001
  - Each responds 3 cycles after accept.
- Memory word 0x004 = 0x11223344, sb addr 0x012 data 0xAB → exactly one write, of 0x11AB3344, 3 cycles after accept. resp_valid 4 cycles after accept.
- lw at 0x011 and sw at 0x012 → resp_err=1 one cycle after accept, mem_we never asserted, resp_rdata=0.
- With LSU_HALFWORD_EN and word 0x8001_7FFE:
  - lh at 0x012 → 0xFFFF8001.
  - sh at 0x010 data 0x1234 → word becomes 0x80011234.

  Without the macro, the same lh returns err=1 with no memory access.
- Start sb, then assert rst in the EXT cycle → mem_we stays 0, target word unchanged, all outputs at reset values, and the next request is accepted normally after reset is released.
